// File: rtl/cpu_clk_stretch_ctrl_pkg.sv
// rtl/cpu_clk_stretch_ctrl_pkg.sv - shared types, widths and speed-select helper
// for the 65816 phi2 clock-stretch controller.
package cpu_clk_stretch_ctrl_pkg;

  localparam int CNT_W = 4;
  localparam int DIP_W = 2;

  typedef enum logic [4:0] {
    FAST_LO    = 5'b00001,
    FAST_HI    = 5'b00010,
    WAIT_ALIGN = 5'b00100,
    HOST_HI    = 5'b01000,
    HOST_HOLD  = 5'b10000
  } state_e;

  function automatic logic [CNT_W-1:0] sel_half(input logic [DIP_W-1:0] sel,
                                                input int h0, input int h1,
                                                input int h2, input int h3);
    int h;
    case (sel)
      2'b00:   h = h0;
      2'b01:   h = h1;
      2'b10:   h = h2;
      default: h = h3;
    endcase
    return h[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/cpu_clk_stretch_ctrl_if.sv
// rtl/cpu_clk_stretch_ctrl_if.sv - host/CPU clocking signals between the board
// side (master) and the stretch controller (slave).
interface cpu_clk_stretch_ctrl_if;
  import cpu_clk_stretch_ctrl_pkg::*;

  logic             host_phi0;
  logic [DIP_W-1:0] dip;
  logic             host_req;
  logic             cpu_phi2;
  logic             host_cycle;
  logic             host_timeout;

  modport master (
    output host_phi0, dip, host_req,
    input  cpu_phi2, host_cycle, host_timeout
  );

  modport slave (
    input  host_phi0, dip, host_req,
    output cpu_phi2, host_cycle, host_timeout
  );

endinterface

// File: rtl/cpu_clk_stretch_ctrl_sync_ff.sv
// rtl/cpu_clk_stretch_ctrl_sync_ff.sv - multi-flop synchroniser with async reset,
// brings host_phi0 into the hsclk domain.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cpu_clk_stretch_ctrl.sv
// rtl/cpu_clk_stretch_ctrl.sv - generates cpu_phi2 from hsclk at a DIP-selected
// fast rate, stretching and aligning it to host phi0 for host-bus cycles.
module cpu_clk_stretch_ctrl
  import cpu_clk_stretch_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HALF0       = 1,
  parameter int HALF1       = 2,
  parameter int HALF2       = 3,
  parameter int HALF3       = 4,
  parameter int HOLD        = 1,
  parameter int TIMEOUT     = 64
) (
  input logic                   hsclk,
  input logic                   rst,
  cpu_clk_stretch_ctrl_if.slave bus
);

  localparam int     WD_W      = $clog2(TIMEOUT + 1);
  localparam state_e HOLD_NEXT = (HOLD == 0) ? FAST_LO : HOST_HOLD;
  localparam logic   HOLD_HC   = (HOLD != 0);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] half_q;
  logic             first_q;
  logic [WD_W-1:0]  wd_q;
  logic             phi0_dly_q;
  logic             phi2_q;
  logic             hc_q;
  logic             to_q;

  logic             phi0_s;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] dip_half;
  logic [CNT_W-1:0] half_eff;
  logic [CNT_W-1:0] cnt_inc;
  logic [WD_W-1:0]  wd_inc;
  logic             phase_end;
  logic             hold_end;
  logic             wd_fire;

  sync_ff #(.STAGES(SYNC_STAGES)) u_phi0_sync (
    .clk (hsclk),
    .rst (rst),
    .d_i (bus.host_phi0),
    .q_o (phi0_s)
  );

  assign rise = phi0_s & ~phi0_dly_q;
  assign fall = ~phi0_s & phi0_dly_q;

  // The very first low phase after reset has no latched speed yet, so it uses the DIP directly.
  assign dip_half  = sel_half(bus.dip, HALF0, HALF1, HALF2, HALF3);
  assign half_eff  = first_q ? dip_half : half_q;
  assign cnt_inc   = cnt_q + 1'b1;
  assign wd_inc    = wd_q + 1'b1;
  assign phase_end = (cnt_inc == half_eff);
  assign hold_end  = (cnt_inc == CNT_W'(HOLD));
  assign wd_fire   = (wd_inc == WD_W'(TIMEOUT));

  always_ff @(posedge hsclk or posedge rst) begin
    if (rst) begin
      state_q    <= FAST_LO;
      cnt_q      <= '0;
      half_q     <= CNT_W'(HALF0);
      first_q    <= 1'b1;
      wd_q       <= '0;
      phi0_dly_q <= 1'b0;
      phi2_q     <= 1'b0;
      hc_q       <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      phi0_dly_q <= phi0_s;
      case (state_q)
        FAST_LO: begin
          if (first_q) begin
            half_q  <= dip_half;
            first_q <= 1'b0;
          end
          if (phase_end) begin
            cnt_q <= '0;
            if (bus.host_req) begin
              state_q <= WAIT_ALIGN;
              hc_q    <= 1'b1;
              wd_q    <= '0;
            end else begin
              state_q <= FAST_HI;
              phi2_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        FAST_HI: begin
          if (phase_end) begin
            cnt_q   <= '0;
            state_q <= FAST_LO;
            phi2_q  <= 1'b0;
            half_q  <= dip_half;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        WAIT_ALIGN: begin
          // An edge already seen before entry never triggers: only a fresh rise aligns.
          if (rise) begin
            state_q <= HOST_HI;
            phi2_q  <= 1'b1;
            wd_q    <= '0;
          end else if (fall) begin
            wd_q <= '0;
          end else if (wd_fire) begin
            wd_q    <= wd_inc;
            to_q    <= 1'b1;
            state_q <= HOLD_NEXT;
            hc_q    <= HOLD_HC;
            cnt_q   <= '0;
          end else begin
            wd_q <= wd_inc;
          end
        end
        HOST_HI: begin
          if (fall || (!rise && wd_fire)) begin
            if (!fall) to_q <= 1'b1;
            wd_q    <= fall ? '0 : wd_inc;
            state_q <= HOLD_NEXT;
            phi2_q  <= 1'b0;
            hc_q    <= HOLD_HC;
            cnt_q   <= '0;
          end else if (rise) begin
            wd_q <= '0;
          end else begin
            wd_q <= wd_inc;
          end
        end
        HOST_HOLD: begin
          if (hold_end) begin
            state_q <= FAST_LO;
            hc_q    <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= FAST_LO;
          cnt_q   <= '0;
          phi2_q  <= 1'b0;
          hc_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_phi2     = phi2_q;
  assign bus.host_cycle   = hc_q;
  assign bus.host_timeout = to_q;

endmodule
